// File: rtl/fsm_input_conditioner_pkg.sv
// rtl/fsm_input_conditioner_pkg.sv - shared constants and counter sizing for the input conditioner
package fsm_cond_pkg;

  localparam int COND_WIDTH            = 8;
  localparam int COND_DEBOUNCE_DEFAULT = 4;

  // Counter must hold 0..debounce_cycles-1; sized with one spare code for simplicity.
  function automatic int cond_cnt_width(input int debounce_cycles);
    return $clog2(debounce_cycles + 1);
  endfunction

endpackage

// File: rtl/fsm_input_conditioner_debounce_bit.sv
// rtl/fsm_input_conditioner_debounce_bit.sv - one-bit synchronizer, debounce counter and rise strobe
// Optional rise strobe flop is built only when FSM_COND_RISE_EN is defined.
module debounce_bit
  import fsm_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = COND_DEBOUNCE_DEFAULT,
  parameter int CNT_W           = cond_cnt_width(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic busy_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    // Any return to the stable level restarts the window, so bounce never accumulates.
    if (s2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = s2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= raw_i;
      s2_q    <= s1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef FSM_COND_RISE_EN
  logic rise_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_q <= 1'b0;
    end else begin
      rise_q <= level_d & ~level_q;
    end
  end

  assign rise_o = rise_q;
`else
  assign rise_o = 1'b0;
`endif

  assign level_o = level_q;
  assign busy_o  = |cnt_q;

endmodule

// File: rtl/fsm_input_conditioner.sv
// rtl/fsm_input_conditioner.sv - synchronizes and debounces the ui_in pad inputs for tt_um_fsm_top
// Rise strobes on rise_o are generated only when FSM_COND_RISE_EN is defined.
module fsm_input_conditioner
  import fsm_cond_pkg::*;
#(
  parameter int WIDTH           = COND_WIDTH,
  parameter int DEBOUNCE_CYCLES = COND_DEBOUNCE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH-1:0] rise_o,
  output logic             busy_o
);

  logic [WIDTH-1:0] busy_vec;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce_bit (
      .clk    (clk),
      .rst    (rst),
      .raw_i  (raw_i[i]),
      .level_o(level_o[i]),
      .rise_o (rise_o[i]),
      .busy_o (busy_vec[i])
    );
  end

  assign busy_o = |busy_vec;

endmodule

// File: tb/tb_fsm_input_conditioner.sv
// tb/tb_fsm_input_conditioner.sv - directed self-checking bench for fsm_input_conditioner
module tb_fsm_input_conditioner;

`ifdef FSM_COND_RISE_EN
  localparam bit RISE_EN = 1'b1;
`else
  localparam bit RISE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] raw_i = 8'h00;
  logic [7:0] level_o;
  logic [7:0] rise_o;
  logic       busy_o;

  int checks   = 0;
  int failures = 0;

  fsm_input_conditioner #(
    .WIDTH          (8),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .raw_i  (raw_i),
    .level_o(level_o),
    .rise_o (rise_o),
    .busy_o (busy_o)
  );

  always #5 clk = ~clk;

  // Inputs change on negedges; outputs are read on negedges, i.e. after edge k+j.
  task automatic quiet(input logic [7:0] val);
    raw_i = val;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    raw_i = 8'hFF;
    repeat (3) @(negedge clk);
    checks++;
    if (level_o !== 8'h00 || rise_o !== 8'h00 || busy_o !== 1'b0) begin
      $display("FAIL reset_hold level=%h rise=%h busy=%b required 00 00 0", level_o, rise_o, busy_o);
      failures++;
    end
    rst = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (level_o !== 8'hFF) begin
      $display("FAIL reset_release_level level=%h required ff", level_o);
      failures++;
    end
    rst = 1'b1;
    #1;
    checks++;
    if (level_o !== 8'h00 || rise_o !== 8'h00 || busy_o !== 1'b0) begin
      $display("FAIL reset_async level=%h rise=%h busy=%b required 00 00 0", level_o, rise_o, busy_o);
      failures++;
    end
    raw_i = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_clean_step();
    logic [7:0] exp_level, exp_rise;
    logic       exp_busy;
    for (int j = 0; j < 8; j++) begin
      raw_i = 8'h01;
      @(negedge clk);
      exp_level = (j >= 5) ? 8'h01 : 8'h00;
      exp_rise  = (RISE_EN && j == 5) ? 8'h01 : 8'h00;
      exp_busy  = (j >= 2 && j <= 4);
      checks++;
      if (level_o !== exp_level || rise_o !== exp_rise || busy_o !== exp_busy) begin
        $display("FAIL clean_step j=%0d level=%h rise=%h busy=%b required %h %h %b",
                 j, level_o, rise_o, busy_o, exp_level, exp_rise, exp_busy);
        failures++;
      end
    end
    quiet(8'h00);
  endtask

  task automatic test_glitch();
    logic exp_busy;
    for (int j = 0; j < 9; j++) begin
      raw_i = (j < 3) ? 8'h08 : 8'h00;
      @(negedge clk);
      exp_busy = (j >= 2 && j <= 4);
      checks++;
      if (level_o !== 8'h00 || rise_o !== 8'h00 || busy_o !== exp_busy) begin
        $display("FAIL glitch j=%0d level=%h rise=%h busy=%b required 00 00 %b",
                 j, level_o, rise_o, busy_o, exp_busy);
        failures++;
      end
    end
  endtask

  task automatic test_bounce();
    logic [6:0]  pat;
    logic [11:0] busy_tab;
    logic [7:0]  exp_level, exp_rise;
    pat      = 7'b1111011;       // bit j = raw_i[5] sampled at edge k+j
    busy_tab = 12'b0000_1110_1100;
    for (int j = 0; j < 12; j++) begin
      raw_i = (j < 7) ? {2'b00, pat[j], 5'b00000} : 8'h20;
      @(negedge clk);
      exp_level = (j >= 8) ? 8'h20 : 8'h00;
      exp_rise  = (RISE_EN && j == 8) ? 8'h20 : 8'h00;
      checks++;
      if (level_o !== exp_level || rise_o !== exp_rise || busy_o !== busy_tab[j]) begin
        $display("FAIL bounce j=%0d level=%h rise=%h busy=%b required %h %h %b",
                 j, level_o, rise_o, busy_o, exp_level, exp_rise, busy_tab[j]);
        failures++;
      end
    end
    quiet(8'h00);
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp_level, exp_rise;
    logic       exp_busy;
    for (int j = 0; j < 8; j++) begin
      raw_i = 8'hA5;
      @(negedge clk);
      exp_level = (j >= 5) ? 8'hA5 : 8'h00;
      exp_rise  = (RISE_EN && j == 5) ? 8'hA5 : 8'h00;
      exp_busy  = (j >= 2 && j <= 4);
      checks++;
      if (level_o !== exp_level || rise_o !== exp_rise || busy_o !== exp_busy) begin
        $display("FAIL simul_rise j=%0d level=%h rise=%h busy=%b required %h %h %b",
                 j, level_o, rise_o, busy_o, exp_level, exp_rise, exp_busy);
        failures++;
      end
    end
    for (int j = 0; j < 8; j++) begin
      raw_i = 8'h00;
      @(negedge clk);
      exp_level = (j >= 5) ? 8'h00 : 8'hA5;
      exp_busy  = (j >= 2 && j <= 4);
      checks++;
      if (level_o !== exp_level || rise_o !== 8'h00 || busy_o !== exp_busy) begin
        $display("FAIL simul_fall j=%0d level=%h rise=%h busy=%b required %h 00 %b",
                 j, level_o, rise_o, busy_o, exp_level, exp_busy);
        failures++;
      end
    end
  endtask

  task automatic test_reset_mid_window();
    logic [7:0] exp_level, exp_rise;
    for (int j = 0; j < 4; j++) begin
      raw_i = 8'h02;
      @(negedge clk);
    end
    checks++;
    if (busy_o !== 1'b1 || level_o !== 8'h00) begin
      $display("FAIL mid_window_pre busy=%b level=%h required 1 00", busy_o, level_o);
      failures++;
    end
    rst = 1'b1;
    #1;
    checks++;
    if (busy_o !== 1'b0 || level_o !== 8'h00 || rise_o !== 8'h00) begin
      $display("FAIL mid_window_async busy=%b level=%h rise=%h required 0 00 00", busy_o, level_o, rise_o);
      failures++;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      exp_level = (j >= 5) ? 8'h02 : 8'h00;
      exp_rise  = (RISE_EN && j == 5) ? 8'h02 : 8'h00;
      checks++;
      if (level_o !== exp_level || rise_o !== exp_rise) begin
        $display("FAIL mid_window_release j=%0d level=%h rise=%h required %h %h",
                 j, level_o, rise_o, exp_level, exp_rise);
        failures++;
      end
    end
    quiet(8'h00);
  endtask

  initial begin
    test_reset();
    test_clean_step();
    test_glitch();
    test_bounce();
    test_simultaneous();
    test_reset_mid_window();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
